// File: rtl/nv_obs_pkg.sv
// ---------------------------------------------------------------------------
// nv_obs_pkg
// Shared definitions for the observation-sink arbiter: FSM state encoding,
// parameter defaults and the 8-bit MISR tap set with its step function.
// ---------------------------------------------------------------------------
package nv_obs_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } obs_state_e;

    localparam int unsigned OBS_DW_DEF        = 8;
    localparam int unsigned OBS_BURST_MAX_DEF = 16;
    localparam int unsigned OBS_TIMEOUT_DEF   = 16;

    // Feedback taps at bits 7, 5, 4 and 3 of the 8-bit signature.
    localparam logic [7:0] OBS_MISR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] obs_misr_step(input logic [7:0] sig_in,
                                                 input logic [7:0] data_in);
        return {sig_in[6:0], ^(sig_in & OBS_MISR_TAPS)} ^ data_in;
    endfunction

endpackage

// File: rtl/nv_obs_rr_pick.sv
// ---------------------------------------------------------------------------
// nv_obs_rr_pick
// Round-robin priority picker: returns the index of the first set request
// bit at or after ptr, wrapping modulo NUM_REQ.
//   req      in   NUM_REQ  request vector
//   ptr      in   SW       starting priority position
//   gnt_idx  out  SW       selected index (0 when no request is set)
//   any      out  1        at least one request bit is set
// ---------------------------------------------------------------------------
module nv_obs_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SW-1:0]      ptr,
    output logic [SW-1:0]      gnt_idx,
    output logic               any
);

    logic          w_found;
    logic [SW-1:0] w_idx;

    always_comb begin
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = SW'((32'(ptr) + i) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                gnt_idx = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/nv_obs_sink_arb.sv
// ---------------------------------------------------------------------------
// nv_obs_sink_arb
// Round-robin arbiter that grants one of NUM_REQ requesters access to a
// shared observation sink for a burst, passes beats straight through, folds
// every accepted beat into an 8-bit MISR signature, and aborts a grant that
// stalls for TIMEOUT consecutive cycles (sticky err_timeout).
//   nvdla_core_clk  in   1           clock, rising edge
//   nvdla_core_rst  in   1           synchronous active-high reset
//   req_vld         in   NUM_REQ     per-requester beat valid
//   req_data        in   NUM_REQ*DW  per-requester data, i at [i*DW +: DW]
//   req_last        in   NUM_REQ     per-requester last-beat flag
//   req_rdy         out  NUM_REQ     per-requester beat accept
//   sink_vld        out  1           beat valid toward the sink
//   sink_data       out  DW          beat data toward the sink
//   sink_src        out  clog2(N)    granted requester index
//   sink_rdy        in   1           sink backpressure
//   sig_clr         in   1           clear signature (wins over a beat)
//   sig             out  DW          MISR signature
//   err_timeout     out  1           sticky stall-timeout flag
// ---------------------------------------------------------------------------
module nv_obs_sink_arb
    import nv_obs_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DW        = OBS_DW_DEF,
    parameter int unsigned BURST_MAX = OBS_BURST_MAX_DEF,
    parameter int unsigned TIMEOUT   = OBS_TIMEOUT_DEF
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rst,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*DW-1:0]      req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic                       sink_vld,
    output logic [DW-1:0]              sink_data,
    output logic [$clog2(NUM_REQ)-1:0] sink_src,
    input  logic                       sink_rdy,
    input  logic                       sig_clr,
    output logic [DW-1:0]              sig,
    output logic                       err_timeout
);

    localparam int unsigned SW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    obs_state_e    r_state;
    logic [SW-1:0] r_gnt;
    logic [SW-1:0] r_ptr;
    logic [BW-1:0] r_beat_cnt;
    logic [TW-1:0] r_stall_cnt;
    logic [DW-1:0] r_sig;
    logic          r_err;

    logic [SW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic          w_beat;
    logic          w_end_burst;
    logic          w_stall_full;
    logic [SW-1:0] w_ptr_next;

    nv_obs_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SW      (SW)
    ) u_pick (
        .req     (req_vld),
        .ptr     (r_ptr),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    // Zero-latency pass-through of the granted requester while BUSY.
    always_comb begin
        req_rdy   = '0;
        sink_vld  = 1'b0;
        sink_data = '0;
        if (r_state == ST_BUSY) begin
            sink_vld       = req_vld[r_gnt];
            sink_data      = req_data[int'(r_gnt)*DW +: DW];
            req_rdy[r_gnt] = sink_rdy;
        end
    end

    assign w_beat       = (r_state == ST_BUSY) && req_vld[r_gnt] && sink_rdy;
    // The current beat is the BURST_MAX-th when the count still reads one less.
    assign w_end_burst  = req_last[r_gnt] || (r_beat_cnt == BW'(BURST_MAX - 1));
    // This stall cycle is the TIMEOUT-th consecutive one.
    assign w_stall_full = (r_stall_cnt == TW'(TIMEOUT - 1));
    assign w_ptr_next   = (r_gnt == SW'(NUM_REQ - 1)) ? '0 : r_gnt + SW'(1);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_ptr       <= '0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_sig       <= '0;
            r_err       <= 1'b0;
        end else begin
            if (sig_clr) begin
                r_sig <= '0;
            end else if (w_beat) begin
                r_sig <= obs_misr_step(r_sig, sink_data);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt       <= w_pick_idx;
                        r_beat_cnt  <= '0;
                        r_stall_cnt <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_beat) begin
                        r_stall_cnt <= '0;
                        if (w_end_burst) begin
                            r_beat_cnt <= '0;
                            r_ptr      <= w_ptr_next;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BW'(1);
                        end
                    end else if (w_stall_full) begin
                        r_err       <= 1'b1;
                        r_beat_cnt  <= '0;
                        r_stall_cnt <= '0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sink_src    = r_gnt;
    assign sig         = r_sig;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_nv_obs_sink_arb.sv
// ---------------------------------------------------------------------------
// tb_nv_obs_sink_arb
// Self-checking bench for nv_obs_sink_arb. Per-requester source queues feed
// beats; the expected (source, data) order is pushed to a scoreboard when
// stimulus is set up and popped as the sink accepts beats. An independent
// MISR model tracks the expected signature every cycle.
// ---------------------------------------------------------------------------
module tb_nv_obs_sink_arb;

    localparam int NR = 4;
    localparam int DW = 8;

    logic              clk         = 1'b0;
    logic              rst         = 1'b1;
    logic [NR-1:0]     req_vld     = '0;
    logic [NR*DW-1:0]  req_data    = '0;
    logic [NR-1:0]     req_last    = '0;
    logic [NR-1:0]     req_rdy;
    logic              sink_vld;
    logic [DW-1:0]     sink_data;
    logic [1:0]        sink_src;
    logic              sink_rdy    = 1'b1;
    logic              sig_clr     = 1'b0;
    logic [DW-1:0]     sig;
    logic              err_timeout;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          n;
    logic [8:0]  src_q [NR][$];
    logic [9:0]  exp_q [$];
    int          beat_cyc [$];
    logic [7:0]  m_sig  = '0;
    logic [9:0]  mon_e;
    logic [NR-1:0] acc  = '0;
    logic [NR-1:0] mute = '0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    nv_obs_sink_arb #(
        .NUM_REQ   (4),
        .DW        (8),
        .BURST_MAX (16),
        .TIMEOUT   (16)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req_vld        (req_vld),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_rdy        (req_rdy),
        .sink_vld       (sink_vld),
        .sink_data      (sink_data),
        .sink_src       (sink_src),
        .sink_rdy       (sink_rdy),
        .sig_clr        (sig_clr),
        .sig            (sig),
        .err_timeout    (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ d;
    endfunction

    function automatic bit src_busy();
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic add_src(input int i, input logic [7:0] d, input logic l);
        src_q[i].push_back({l, d});
    endtask

    task automatic add_exp(input int i, input logic [7:0] d);
        exp_q.push_back({2'(i), d});
    endtask

    task automatic wait_vld(input string tag);
        int k = 0;
        sample();
        while (!sink_vld && k < 20) begin
            sample();
            k++;
        end
        chk(tag, 32'(sink_vld), 1);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || src_busy()) && k < 200) begin
            sample();
            k++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    always @(posedge clk) cyc++;

    // Source side: retire the beat accepted at this edge, present the next.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            if (src_q[i].size() != 0 && !mute[i]) begin
                req_vld[i]            = 1'b1;
                req_data[i*DW +: DW]  = src_q[i][0][7:0];
                req_last[i]           = src_q[i][0][8];
            end else begin
                req_vld[i]            = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    end

    // Sink side: scoreboard pop and signature model.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) acc[i] = req_vld[i] & req_rdy[i] & ~rst;
        if (mon_en) chk("sig", 32'(sig), 32'(m_sig));
        if (mon_en && !rst && sink_vld && sink_rdy) begin
            beat_cyc.push_back(cyc);
            chk("beat_avail", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("src", 32'(sink_src), 32'(mon_e[9:8]));
                chk("data", 32'(sink_data), 32'(mon_e[7:0]));
                m_sig = misr(m_sig, mon_e[7:0]);
            end
        end
        if (rst || sig_clr) m_sig = '0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        sample();
        chk("rst_vld", 32'(sink_vld), 0);
        chk("rst_rdy", 32'(req_rdy), 0);
        chk("rst_src", 32'(sink_src), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_sig", 32'(sig), 0);
        mon_en = 1'b1;
        tick();
        rst = 1'b0;

        // Scenario 1: requesters 1 and 2 from reset, one IDLE cycle between
        beat_cyc.delete();
        add_src(1, 8'h11, 1'b0); add_src(1, 8'h12, 1'b1);
        add_src(2, 8'h21, 1'b0); add_src(2, 8'h22, 1'b1);
        add_exp(1, 8'h11); add_exp(1, 8'h12);
        add_exp(2, 8'h21); add_exp(2, 8'h22);
        sample();
        chk("s1_idle_rdy", 32'(req_rdy), 0);
        chk("s1_idle_vld", 32'(sink_vld), 0);
        drain("s1_drain");
        chk("s1_nbeats", beat_cyc.size(), 4);
        if (beat_cyc.size() == 4) begin
            chk("s1_b2b", 32'(beat_cyc[1] - beat_cyc[0]), 1);
            chk("s1_gap", 32'(beat_cyc[2] - beat_cyc[1]), 2);
        end

        // Scenario 2: 20-beat stream from requester 0 capped at 16
        tick();
        beat_cyc.delete();
        for (int i = 0; i < 20; i++) add_src(0, 8'(8'h40 + i), (i == 19));
        add_src(1, 8'hA0, 1'b1);
        for (int i = 0; i < 16; i++) add_exp(0, 8'(8'h40 + i));
        add_exp(1, 8'hA0);
        for (int i = 16; i < 20; i++) add_exp(0, 8'(8'h40 + i));
        drain("s2_drain");
        chk("s2_nbeats", beat_cyc.size(), 21);
        if (beat_cyc.size() == 21) begin
            chk("s2_stream", 32'(beat_cyc[15] - beat_cyc[0]), 15);
            chk("s2_cap_gap", 32'(beat_cyc[16] - beat_cyc[15]), 2);
            chk("s2_next_gap", 32'(beat_cyc[17] - beat_cyc[16]), 2);
        end

        // Scenario 3: clear, then 0x01 and 0x02
        tick();
        sig_clr = 1'b1;
        tick();
        sig_clr = 1'b0;
        sample();
        chk("s3_clr", 32'(sig), 0);
        tick();
        add_src(3, 8'h01, 1'b0); add_src(3, 8'h02, 1'b1);
        add_exp(3, 8'h01); add_exp(3, 8'h02);
        n = 0;
        while (exp_q.size() == 2 && n < 20) begin
            sample();
            n++;
        end
        sample();
        chk("s3_sig1", 32'(sig), 32'h01);
        drain("s3_drain");
        sample();
        chk("s3_sig2", 32'(sig), 32'h00);

        // Clear coinciding with a beat
        tick();
        sink_rdy = 1'b0;
        add_src(2, 8'h5A, 1'b1);
        add_exp(2, 8'h5A);
        wait_vld("s3_busy");
        tick();
        sink_rdy = 1'b1;
        sig_clr  = 1'b1;
        tick();
        sig_clr  = 1'b0;
        sample();
        chk("s3_clr_wins", 32'(sig), 0);
        drain("s3_drain2");

        // Scenario 5: 5-cycle backpressure mid-burst
        tick();
        add_src(1, 8'h31, 1'b0); add_src(1, 8'h32, 1'b0); add_src(1, 8'h33, 1'b1);
        add_exp(1, 8'h31); add_exp(1, 8'h32); add_exp(1, 8'h33);
        n = 0;
        while (exp_q.size() > 2 && n < 20) begin
            sample();
            n++;
        end
        tick();
        sink_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("s5_rdy", 32'(req_rdy), 0);
            chk("s5_vld", 32'(sink_vld), 1);
            chk("s5_held", exp_q.size(), 2);
        end
        tick();
        sink_rdy = 1'b1;
        drain("s5_drain");

        // Scenario 4: granted requester goes silent -> timeout
        tick();
        sink_rdy = 1'b0;
        add_src(2, 8'h77, 1'b1);
        wait_vld("s4_busy");
        chk("s4_src", 32'(sink_src), 2);
        tick();
        mute[2] = 1'b1;
        n = 0;
        do begin
            sample();
            n++;
        end while (!err_timeout && n < 40);
        chk("s4_cycles", 32'(n), 16);
        chk("s4_err", 32'(err_timeout), 1);
        chk("s4_idle", 32'(req_rdy), 0);
        tick();
        mute[2]  = 1'b0;
        sink_rdy = 1'b1;
        add_src(3, 8'h88, 1'b1);
        add_exp(3, 8'h88);
        add_exp(2, 8'h77);
        drain("s4_drain");
        chk("s4_sticky", 32'(err_timeout), 1);

        // Scenario 6: reset while BUSY with a beat pending
        tick();
        sink_rdy = 1'b0;
        add_src(0, 8'h66, 1'b1);
        wait_vld("s6_busy");
        chk("s6_src", 32'(sink_src), 0);
        tick();
        rst      = 1'b1;
        sink_rdy = 1'b1;
        sample();
        tick();
        rst = 1'b0;
        sample();
        chk("s6_vld", 32'(sink_vld), 0);
        chk("s6_rdy", 32'(req_rdy), 0);
        chk("s6_sig", 32'(sig), 0);
        chk("s6_err", 32'(err_timeout), 0);
        chk("s6_src_rst", 32'(sink_src), 0);
        add_exp(0, 8'h66);
        drain("s6_drain");

        repeat (3) sample();
        chk("end_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
